nios_keycode_rx_fifo: RTL and testbench

//  Hardware-to-CPU keycode path: opposite direction of the CPU-written keycode PIO.

---
 rtl/nios_keycode_rx_fifo.sv | 83 ++++++++
 tb/tb_nios_keycode_rx_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nios_keycode_rx_fifo.sv
// Keycode receive FIFO: keyboard logic pushes codes, NIOS pops them over an Avalon-MM slave.
// Zero read latency; level irq while data is pending and enabled; pushes into a full FIFO are dropped and flagged.
module nios_keycode_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] key_data,
    input  logic          key_valid,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          read_n,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          ovf, irq_en, irq_en_nxt;
    logic          empty, full, rd_sel, wr_sel, pop, push, ovf_set, ovf_clr;
    logic          unused_wdata;

    assign unused_wdata = ^writedata[31:1];

    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        rd_sel     = chipselect & ~read_n;
        wr_sel     = chipselect & ~write_n;
        pop        = rd_sel & (address == 2'd0) & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push       = key_valid & (~full | pop);
        ovf_set    = key_valid & full & ~pop;
        ovf_clr    = wr_sel & (address == 2'd3) & writedata[0];
        irq_en_nxt = (wr_sel && address == 2'd2) ? writedata[0] : irq_en;
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            // Set has priority over a coincident clear.
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            irq_en <= irq_en_nxt;
            irq    <= irq_en_nxt & (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= key_data;
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = empty ? 32'd0 : 32'(mem[rd_ptr]);
            2'd1:    readdata = {16'd0, 8'(count), 5'd0, ovf, full, empty};
            2'd2:    readdata = {31'd0, irq_en};
            default: readdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_nios_keycode_rx_fifo.sv
// Directed bench for nios_keycode_rx_fifo with hand-computed expectations.
module tb_nios_keycode_rx_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  key_data = 8'd0;
    logic        key_valid = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q[$];

    nios_keycode_rx_fifo #(.DEPTH(8), .DW(8)) dut (
        .clk(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
        .address(address), .chipselect(chipselect), .read_n(read_n),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] code);
        key_valid = 1'b1;
        key_data  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        chk(tag, readdata, exp);
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd(2'd1, 32'h0000_0001, "rst_status");
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd2, 32'h0, "rst_ctrl");
        rd(2'd3, 32'h0, "rst_clear");
        chk("rst_irq", 32'(irq), 32'h0);

        // Basic order; writes to DATA must not disturb contents
        push(8'h1C); push(8'h32); push(8'h23);
        wr(2'd0, 32'hFF);
        rd(2'd1, 32'h0000_0300, "t2_status3");
        rd(2'd0, 32'h1C, "t2_d0");
        rd(2'd0, 32'h32, "t2_d1");
        rd(2'd0, 32'h23, "t2_d2");
        rd(2'd1, 32'h0000_0001, "t2_status");

        // Overflow
        for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
        rd(2'd1, 32'h0000_0806, "t3_status_full_ovf");
        for (int i = 0; i < 8; i++) rd(2'd0, 32'(8'h10 + i), "t3_drain");
        rd(2'd1, 32'h0000_0005, "t3_status_empty_ovf");
        wr(2'd3, 32'h1);
        rd(2'd1, 32'h0000_0001, "t3_status_cleared");

        // Set and clear in the same cycle: set wins
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        key_valid = 1'b1; key_data = 8'h99;
        wr(2'd3, 32'h1);
        key_valid = 1'b0;
        rd(2'd1, 32'h0000_0806, "ovf_set_wins");
        wr(2'd3, 32'h1);
        for (int i = 0; i < 8; i++) rd(2'd0, 32'(8'h50 + i), "ovf_drain");

        // Full FIFO: push coincident with pop is accepted
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        key_valid = 1'b1; key_data = 8'h44;
        rd(2'd0, 32'h20, "t4_old_head");
        key_valid = 1'b0;
        rd(2'd1, 32'h0000_0802, "t4_status");
        for (int i = 1; i < 8; i++) rd(2'd0, 32'(8'h20 + i), "t4_drain");
        rd(2'd0, 32'h44, "t4_last");
        rd(2'd1, 32'h0000_0001, "t4_empty");

        // Interrupt
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "t5_ctrl");
        chk("t5_irq_idle", 32'(irq), 32'h0);
        push(8'h04);
        chk("t5_irq_set", 32'(irq), 32'h1);
        rd(2'd0, 32'h04, "t5_data");
        chk("t5_irq_clr", 32'(irq), 32'h0);
        push(8'h05);
        chk("t5_irq_set2", 32'(irq), 32'h1);
        wr(2'd2, 32'h0);
        chk("t5_irq_disabled", 32'(irq), 32'h0);
        rd(2'd1, 32'h0000_0100, "t5_status");
        rd(2'd0, 32'h05, "t5_drain");

        // Mid-operation reset with coincident push and pop ignored
        for (int i = 0; i < 9; i++) push(8'(8'h60 + i));
        wr(2'd2, 32'h1);
        chk("t6_irq_pre", 32'(irq), 32'h1);
        reset = 1'b1; key_valid = 1'b1; key_data = 8'h77;
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        tick();
        reset = 1'b0; key_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
        rd(2'd1, 32'h0000_0001, "t6_status");
        rd(2'd2, 32'h0, "t6_ctrl");
        rd(2'd0, 32'h0, "t6_data");
        chk("t6_irq", 32'(irq), 32'h0);

        // Push+read on empty: pop suppressed, push accepted
        key_valid = 1'b1; key_data = 8'hA5;
        rd(2'd0, 32'h0, "empty_pushpop_data");
        key_valid = 1'b0;
        rd(2'd1, 32'h0000_0100, "empty_pushpop_status");
        rd(2'd0, 32'hA5, "empty_pushpop_head");

        // Pointer wrap: 20 pushes, reads interleaved, order tracked by a queue
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h80 + i));
            q.push_back(8'(8'h80 + i));
            if (q.size() >= 3) rd(2'd0, 32'(q.pop_front()), "wrap_data");
        end
        while (q.size() > 0) rd(2'd0, 32'(q.pop_front()), "wrap_drain");
        rd(2'd1, 32'h0000_0001, "wrap_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
